rr_priority_arbiter: RTL and testbench

- Registered N-way arbiter. It generalises the combinational lowest-index priority encoder in two ways: a selectable round-robin mode and a valid/ready grant handshake.
- Sits between multiple request sources and a single shared resource.
- Each cycle it can issue one grant.
- The grant holds stable until the consumer accepts it.

---
 rtl/rr_priority_arbiter.sv | 93 +++++++++
 tb/tb_rr_priority_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with selectable round-robin or fixed lowest-index
// priority, presenting one grant at a time through a valid/ready handshake.
module rr_priority_arbiter #(
  parameter int N_REQ       = 8,
  parameter bit ROUND_ROBIN = 1'b1,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             any_req
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic             win_found;
  logic             accept;
  logic             load;

  assign any_req = |req;
  assign accept  = out_valid && out_ready;
  assign load    = !out_valid || out_ready;

  // The winner of a re-arbitration must already see the pointer moved past the
  // grant being accepted on the same edge, so the scan starts from ptr_next.
  always_comb begin
    ptr_next = ptr;
    if (ROUND_ROBIN && accept) begin
      ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
    base = ROUND_ROBIN ? ptr_next : '0;
  end

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, base} + (IDX_W + 1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
    if (win_found) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      ptr          <= '0;
    end else begin
      ptr <= ptr_next;
      if (load) begin
        out_valid    <= win_found;
        grant_onehot <= win_onehot;
        if (win_found) begin
          grant_idx <= win_idx;
        end
      end
    end
  end

  a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> $onehot(grant_onehot));

  a_idx_matches_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    grant_onehot[grant_idx] == out_valid);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(grant_idx) && $stable(grant_onehot)));

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench for rr_priority_arbiter: four configurations driven from
// one clock, expected grants queued at drive time and popped after each edge.
module tb_rr_priority_arbiter;

  typedef struct {
    logic       valid;
    logic [7:0] idx;
    logic [7:0] onehot;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rr5_req, fx5_req;
  logic [7:0] rr8_req;
  logic [0:0] one_req;
  logic       rr5_ready, fx5_ready, rr8_ready, one_ready;
  logic       rr5_valid, fx5_valid, rr8_valid, one_valid;
  logic [2:0] rr5_idx, fx5_idx, rr8_idx;
  logic [0:0] one_idx;
  logic [4:0] rr5_oh, fx5_oh;
  logic [7:0] rr8_oh;
  logic [0:0] one_oh;
  logic       rr5_any, fx5_any, rr8_any, one_any;

  exp_t exp_q[$];
  exp_t e;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  rr_priority_arbiter #(.N_REQ(5), .ROUND_ROBIN(1'b1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(rr5_req), .out_ready(rr5_ready),
    .out_valid(rr5_valid), .grant_idx(rr5_idx), .grant_onehot(rr5_oh), .any_req(rr5_any));

  rr_priority_arbiter #(.N_REQ(5), .ROUND_ROBIN(1'b0)) u_fx5 (
    .clk(clk), .rst_n(rst_n), .req(fx5_req), .out_ready(fx5_ready),
    .out_valid(fx5_valid), .grant_idx(fx5_idx), .grant_onehot(fx5_oh), .any_req(fx5_any));

  rr_priority_arbiter #(.N_REQ(8), .ROUND_ROBIN(1'b1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .req(rr8_req), .out_ready(rr8_ready),
    .out_valid(rr8_valid), .grant_idx(rr8_idx), .grant_onehot(rr8_oh), .any_req(rr8_any));

  rr_priority_arbiter #(.N_REQ(1), .ROUND_ROBIN(1'b1)) u_one (
    .clk(clk), .rst_n(rst_n), .req(one_req), .out_ready(one_ready),
    .out_valid(one_valid), .grant_idx(one_idx), .grant_onehot(one_oh), .any_req(one_any));

  function automatic exp_t mk_exp(input logic v, input int idx);
    exp_t r;
    r.valid  = v;
    r.idx    = v ? 8'(idx) : 8'h0;
    r.onehot = v ? (8'h1 << idx) : 8'h0;
    return r;
  endfunction

  // Reference winner search: rotate from p modulo n, -1 when nothing requests.
  function automatic int ref_winner(input int n, input int p, input logic [7:0] r);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    rr5_req = '0; fx5_req = '0; rr8_req = '0; one_req = '0;
    rr5_ready = 1'b0; fx5_ready = 1'b0; rr8_ready = 1'b0; one_ready = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rr5_req = '0; fx5_req = '0; rr8_req = '0; one_req = '0;
    rr5_ready = 1'b0; fx5_ready = 1'b0; rr8_ready = 1'b0; one_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    n_compared++;
    if (rr5_valid !== 1'b0 || rr5_idx !== 3'd0 || rr5_oh !== 5'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got v=%b idx=%0d oh=%b, want v=0 idx=0 oh=00000",
               rr5_valid, rr5_idx, rr5_oh);
    end
    tick;
    rst_n = 1'b1;
    rr5_req = 5'b10110;
    exp_q.push_back(mk_exp(1'b1, 1));
    tick;
    e = exp_q.pop_front();
    n_compared++;
    if (rr5_valid !== e.valid || {5'b0, rr5_idx} !== e.idx || {3'b0, rr5_oh} !== e.onehot) begin
      n_mismatched++;
      $display("[TB] FAIL grant_before_reset: got v=%b idx=%0d oh=%b, want v=%b idx=%0d oh=%b",
               rr5_valid, rr5_idx, rr5_oh, e.valid, e.idx, e.onehot[4:0]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (rr5_valid !== 1'b0 || rr5_idx !== 3'd0 || rr5_oh !== 5'd0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset_clears: got v=%b idx=%0d oh=%b, want v=0 idx=0 oh=00000",
               rr5_valid, rr5_idx, rr5_oh);
    end
    n_compared++;
    if (rr5_any !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL any_req_in_reset: got %b, want 1", rr5_any);
    end
    rr5_req = '0;
    #1;
    rst_n = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 0));
    tick;
    e = exp_q.pop_front();
    n_compared++;
    if (rr5_valid !== e.valid || {5'b0, rr5_idx} !== e.idx || {3'b0, rr5_oh} !== e.onehot
        || rr5_any !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_after_reset: got v=%b idx=%0d oh=%b any=%b, want v=0 idx=0 oh=00000 any=0",
               rr5_valid, rr5_idx, rr5_oh, rr5_any);
    end
  endtask

  task automatic test_fixed_priority;
    apply_reset;
    fx5_req   = 5'b10110;
    fx5_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_exp(1'b1, 1));
      tick;
      e = exp_q.pop_front();
      n_compared++;
      if (fx5_valid !== e.valid || {5'b0, fx5_idx} !== e.idx || {3'b0, fx5_oh} !== e.onehot) begin
        n_mismatched++;
        $display("[TB] FAIL fixed_priority[%0d]: got v=%b idx=%0d oh=%b, want v=%b idx=%0d oh=%b",
                 i, fx5_valid, fx5_idx, fx5_oh, e.valid, e.idx, e.onehot[4:0]);
      end
    end
  endtask

  task automatic test_rotation;
    apply_reset;
    rr5_req   = 5'b11111;
    rr5_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk_exp(1'b1, i % 5));
      tick;
      e = exp_q.pop_front();
      n_compared++;
      if (rr5_valid !== e.valid || {5'b0, rr5_idx} !== e.idx || {3'b0, rr5_oh} !== e.onehot) begin
        n_mismatched++;
        $display("[TB] FAIL rotation[%0d]: got v=%b idx=%0d oh=%b, want v=%b idx=%0d oh=%b",
                 i, rr5_valid, rr5_idx, rr5_oh, e.valid, e.idx, e.onehot[4:0]);
      end
    end
  endtask

  task automatic test_backpressure;
    apply_reset;
    rr5_req   = 5'b00100;
    rr5_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) rr5_req = 5'b00001;
      if (i == 4) rr5_ready = 1'b1;
      exp_q.push_back(mk_exp(1'b1, (i == 4) ? 0 : 2));
      tick;
      e = exp_q.pop_front();
      n_compared++;
      if (rr5_valid !== e.valid || {5'b0, rr5_idx} !== e.idx || {3'b0, rr5_oh} !== e.onehot) begin
        n_mismatched++;
        $display("[TB] FAIL backpressure[%0d]: got v=%b idx=%0d oh=%b, want v=%b idx=%0d oh=%b",
                 i, rr5_valid, rr5_idx, rr5_oh, e.valid, e.idx, e.onehot[4:0]);
      end
    end
  endtask

  task automatic test_pointer_skip;
    apply_reset;
    rr8_req   = 8'b01000000;
    rr8_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) rr8_req = 8'b01000001;
      exp_q.push_back(mk_exp(1'b1, (i == 1) ? 0 : 6));
      tick;
      e = exp_q.pop_front();
      n_compared++;
      if (rr8_valid !== e.valid || {5'b0, rr8_idx} !== e.idx || rr8_oh !== e.onehot) begin
        n_mismatched++;
        $display("[TB] FAIL pointer_skip[%0d]: got v=%b idx=%0d oh=%b, want v=%b idx=%0d oh=%b",
                 i, rr8_valid, rr8_idx, rr8_oh, e.valid, e.idx, e.onehot);
      end
    end
  endtask

  task automatic test_single_requester;
    logic [6:0] req_seq   = 7'b0001101;
    logic [6:0] ready_seq = 7'b1001111;
    logic [6:0] valid_seq = 7'b0111101;
    apply_reset;
    for (int i = 0; i < 7; i++) begin
      one_req   = req_seq[i];
      one_ready = ready_seq[i];
      exp_q.push_back(mk_exp(valid_seq[i], 0));
      tick;
      e = exp_q.pop_front();
      n_compared++;
      if (one_valid !== e.valid || one_idx !== 1'b0 || {7'b0, one_oh} !== e.onehot) begin
        n_mismatched++;
        $display("[TB] FAIL single_requester[%0d]: got v=%b idx=%0d oh=%b, want v=%b idx=0 oh=%b",
                 i, one_valid, one_idx, one_oh, e.valid, e.onehot[0]);
      end
    end
  endtask

  task automatic test_random_traffic;
    int         m_v, m_idx, m_ptr, f_v, f_idx, np, w;
    logic [4:0] r;
    logic       rd;
    apply_reset;
    m_v = 0; m_idx = 0; m_ptr = 0; f_v = 0; f_idx = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      r  = 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 3) != 0);
      rr5_req = r; fx5_req = r; rr5_ready = rd; fx5_ready = rd;
      np = (m_v != 0 && rd) ? ((m_idx == 4) ? 0 : m_idx + 1) : m_ptr;
      if (m_v == 0 || rd) begin
        w = ref_winner(5, np, {3'b0, r});
        m_v = (w >= 0) ? 1 : 0;
        if (w >= 0) m_idx = w;
      end
      m_ptr = np;
      if (f_v == 0 || rd) begin
        w = ref_winner(5, 0, {3'b0, r});
        f_v = (w >= 0) ? 1 : 0;
        if (w >= 0) f_idx = w;
      end
      exp_q.push_back(mk_exp(m_v != 0, m_idx));
      exp_q.push_back(mk_exp(f_v != 0, f_idx));
      tick;
      e = exp_q.pop_front();
      n_compared++;
      if (rr5_valid !== e.valid || (e.valid && {5'b0, rr5_idx} !== e.idx)
          || {3'b0, rr5_oh} !== e.onehot || rr5_any !== (|r)) begin
        n_mismatched++;
        $display("[TB] FAIL random_rr[%0d]: got v=%b idx=%0d oh=%b any=%b, want v=%b idx=%0d oh=%b any=%b",
                 cyc, rr5_valid, rr5_idx, rr5_oh, rr5_any, e.valid, e.idx, e.onehot[4:0], |r);
      end
      e = exp_q.pop_front();
      n_compared++;
      if (fx5_valid !== e.valid || (e.valid && {5'b0, fx5_idx} !== e.idx)
          || {3'b0, fx5_oh} !== e.onehot) begin
        n_mismatched++;
        $display("[TB] FAIL random_fixed[%0d]: got v=%b idx=%0d oh=%b, want v=%b idx=%0d oh=%b",
                 cyc, fx5_valid, fx5_idx, fx5_oh, e.valid, e.idx, e.onehot[4:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fixed_priority;
    test_rotation;
    test_backpressure;
    test_pointer_skip;
    test_single_requester;
    test_random_traffic;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
